// File: rtl/ioblock_cfg_pkg.sv
// Shared types and constants for the ioblock50 configuration controller.
// Holds the word width, TSMUX encodings, the FSM state encoding and the reserved-encoding check.
package ioblock_cfg_pkg;

    localparam int CFG_W = 3;

    localparam logic [1:0] TS_OFF  = 2'b00;
    localparam logic [1:0] TS_CTRL = 2'b01;
    localparam logic [1:0] TS_RSVD = 2'b10;
    localparam logic [1:0] TS_ON   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_FIN
    } cfg_state_t;

    function automatic logic is_rsvd_ts(input logic [1:0] ts);
        return ts == TS_RSVD;
    endfunction

endpackage

// File: rtl/ioblock_cfg_shifter.sv
// Parallel-in serial-out image register, MSB shown first; load and shift take effect on the next edge.
// No backpressure: shifts every cycle shift is high, load has priority.
module ioblock_cfg_shifter #(
    parameter int W = 24
) (
    input  logic         IOCLK,
    input  logic         RESETN,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    input  logic         shift,
    output logic         sout
);

    logic [W-1:0] sreg_q;

    always_ff @(posedge IOCLK or negedge RESETN) begin
        if (!RESETN) begin
            sreg_q <= '0;
        end else if (load) begin
            sreg_q <= load_dat;
        end else if (shift) begin
            sreg_q <= {sreg_q[W-2:0], 1'b0};
        end
    end

    assign sout = sreg_q[W-1];

endmodule

// File: rtl/ioblock_cfg_ctrl.sv
// Collects one config word per I/O block, shifts the image down the chain and pulses a single latch.
// 4*NUM_IO+2 cycles START->DONE plus host stalls; host throttled by WR_READY (LOAD only), SHIFT never stalls.
module ioblock_cfg_ctrl #(
    parameter int NUM_IO = 8,
    parameter int CFG_W  = 3
) (
    input  logic             IOCLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [CFG_W-1:0] WR_DATA,
    output logic             CFG_DATA,
    output logic             CFG_EN,
    output logic             CFG_LATCH,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    import ioblock_cfg_pkg::*;

    localparam int NBITS = NUM_IO * CFG_W;
    localparam int IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam int BC_W  = $clog2(NBITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IO - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(NBITS - 1);

    cfg_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [BC_W-1:0]  bcnt_q;
    logic [NBITS-1:0] buf_q;
    logic [NBITS-1:0] load_img;
    logic             err_q;
    logic             xfer;
    logic             idx_last;
    logic             bcnt_last;
    logic             shift_out;

    assign idx_last  = (idx_q == IDX_LAST);
    assign bcnt_last = (bcnt_q == BC_LAST);
    assign xfer      = WR_READY & WR_VALID;

    always_ff @(posedge IOCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        WR_READY  = 1'b0;
        BUSY      = 1'b1;
        CFG_EN    = 1'b0;
        CFG_LATCH = 1'b0;
        DONE      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (START) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                WR_READY = 1'b1;
                if (WR_VALID && idx_last) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                CFG_EN = 1'b1;
                if (bcnt_last) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                CFG_LATCH = 1'b1;
                state_d   = ST_FIN;
            end
            ST_FIN: begin
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                BUSY    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Zeroed buffer means TSMUX=off on every block, so a reset never drives pads.
    always_ff @(posedge IOCLK or negedge RESETN) begin
        if (!RESETN) begin
            idx_q  <= '0;
            bcnt_q <= '0;
            buf_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                idx_q  <= '0;
                bcnt_q <= '0;
                if (START) err_q <= 1'b0;
            end
            if (xfer) begin
                buf_q[int'(idx_q) * CFG_W +: CFG_W] <= WR_DATA;
                if (!idx_last) idx_q <= idx_q + IDX_W'(1);
                if (is_rsvd_ts(WR_DATA[CFG_W-1 -: 2])) err_q <= 1'b1;
            end
            if (state_q == ST_SHIFT && !bcnt_last) begin
                bcnt_q <= bcnt_q + BC_W'(1);
            end
        end
    end

    // The last word is still on WR_DATA when the shifter loads, so splice it in here.
    always_comb begin
        load_img = buf_q;
        load_img[NBITS-1 -: CFG_W] = WR_DATA;
    end

    ioblock_cfg_shifter #(
        .W(NBITS)
    ) u_shifter (
        .IOCLK   (IOCLK),
        .RESETN  (RESETN),
        .load    (xfer & idx_last),
        .load_dat(load_img),
        .shift   (CFG_EN),
        .sout    (shift_out)
    );

    assign CFG_DATA = shift_out & CFG_EN;
    assign ERR      = err_q;

endmodule

// File: doc/ioblock_cfg_ctrl.md
# ioblock_cfg_ctrl

Configuration controller for the `ioblock50` I/O pad array. It accepts one 3-bit configuration word per I/O block from the host over a valid/ready handshake. It then shifts the whole image serially down the I/O configuration chain and issues a single latch pulse, so every block's TSMUX/DORREG setting changes in the same cycle. It sits between the device configuration port and the I/O ring.

## Interface
Parameters:
- `NUM_IO`, 8, number of I/O blocks on the chain (1..64)
- `CFG_W`, 3, bits per block: {TSMUX[1:0], DORREG}

Ports:
- `IOCLK`  in  1  single clock; all state updates on its rising edge
- `RESETN`  in  1  reset, asynchronous assert, active-low
- `START`  in  1  begin a configuration session; sampled only in IDLE
- `WR_VALID`  in  1  host word valid
- `WR_READY`  out  1  controller can accept a word
- `WR_DATA`  in  CFG_W  config word {TSMUX[1:0], DORREG}; IO index 0 first
- `CFG_DATA`  out  1  serial config bit to chain head
- `CFG_EN`  out  1  chain shift enable, qualifies CFG_DATA
- `CFG_LATCH`  out  1  one-cycle pulse: chain copies shift stages into live config
- `BUSY`  out  1  session in progress
- `DONE`  out  1  one-cycle pulse at session end
- `ERR`  out  1  sticky: a reserved TSMUX encoding was loaded this session

## Operation
- States: IDLE, LOAD, SHIFT, LATCH, FIN.
- IDLE: WR_READY=0, BUSY=0. START=1 -> LOAD. Clear word index, bit counter and ERR.
- LOAD: WR_READY=1. A transfer occurs when WR_VALID && WR_READY. Store WR_DATA in buffer[idx] and increment idx. The transfer with idx==NUM_IO-1 moves to SHIFT. Without WR_VALID, wait indefinitely.
- TSMUX encodings: 00 off (Z), 01 TS-controlled, 10 reserved, 11 always-drive. A word with TSMUX=10 is still stored and sets ERR; ERR holds until the next START.
- SHIFT: CFG_EN=1 for exactly NUM_IO*CFG_W cycles.
  - Block order: highest IO index first, so block 0's word ends nearest the chain head.
  - Bit order within a word: TSMUX[1], TSMUX[0], DORREG.
  - After the last bit -> LATCH.
- LATCH: CFG_EN=0 and CFG_LATCH=1 for one cycle -> FIN.
- FIN: DONE=1 for one cycle -> IDLE.
- BUSY=1 in LOAD, SHIFT, LATCH and FIN.
- START outside IDLE is ignored. Host words presented outside LOAD are not accepted.
- Counter widths: idx is clog2(NUM_IO) bits; bit counter is clog2(NUM_IO*CFG_W) bits. Neither wraps: the terminal compare fires before wrap.
- Reset (any state, including mid-SHIFT): return to IDLE and zero the buffer, which sets TSMUX=00 so all pads stay tri-stated. No CFG_LATCH is issued, so the chain's live config is untouched.

## Timing
- Reset values: WR_READY=0, CFG_DATA=0, CFG_EN=0, CFG_LATCH=0, BUSY=0, DONE=0, ERR=0.
- All outputs are registered or decoded directly from state registers. No combinational path from inputs to outputs except none; WR_READY comes from state only.
- START sampled at edge k puts the FSM in LOAD in cycle k+1.
- With WR_VALID held high, the words transfer in cycles k+1..k+N (N=NUM_IO).
- SHIFT runs from cycle k+N+1 to k+4N (CFG_W=3). The first bit shown is buffer[N-1][2].
- CFG_LATCH is high in cycle k+4N+1 and DONE in k+4N+2. The FSM is back in IDLE at k+4N+3 and can accept START then.
- Total for NUM_IO=8 with no stalls: 34 cycles from START to DONE.
- Each host stall cycle in LOAD adds one cycle. SHIFT is never stalled.

## Structure
- Package `ioblock_cfg_pkg` holds:
  - CFG_W
  - TSMUX encodings TS_OFF=2'b00, TS_CTRL=2'b01, TS_RSVD=2'b10, TS_ON=2'b11
  - the FSM state encoding
  - the helper that checks whether a word is reserved
- Sub-module `ioblock_cfg_shifter`: a parallel-in serial-out register of NUM_IO*CFG_W bits, with load, shift enable and a serial output. It is loaded in the last LOAD cycle and shifted during SHIFT. The top level holds the FSM, counters, handshake and ERR.

## Test plan
- **Reset in IDLE:** deassert RESETN, check every output is 0. Pulse START and drive 8 words 3'b010 back-to-back -> 24 CFG_EN cycles showing pattern 0,1,0 repeated; CFG_LATCH at cycle 33, DONE at 34, ERR=0.
- **Bit ordering:** load words idx0=3'b111, idx7=3'b001, all others 3'b000 -> the first 3 CFG_DATA bits are 0,0,1 and the last 3 are 1,1,1. Check with a behavioural 24-stage chain model that block0 sees TSMUX=11, DORREG=1.
- **Host stalls:** toggle WR_VALID 1,0,1,0 -> exactly 8 transfers occur; DONE arrives at 34 plus the number of stall cycles; no word is duplicated or dropped.
- **Reserved encoding:** word 3 = 3'b100 -> ERR rises the cycle after the transfer and stays 1 through DONE. The next START clears it.
- **START while BUSY:** pulse START mid-SHIFT -> no effect on state, bit count or the DONE cycle.
- **Reset mid-SHIFT:** assert RESETN low at SHIFT bit 10 -> outputs go to 0 immediately and CFG_LATCH is never seen. A fresh session afterwards completes normally in 34 cycles.
